// File: rtl/banked_byte_mem_if.sv
// Bus bundle for banked_byte_mem: command, write-data and read-response channels
// plus status. Master drives requests, slave (the memory) drives responses.
interface banked_byte_mem_if #(
  parameter int BYTES      = 4,
  parameter int ADDR_SIZE  = 32,
  parameter int BURST_BITS = 2
);
  logic                  cmdValid;
  logic                  cmdReady;
  logic [ADDR_SIZE-1:0]  memAddr;
  logic                  memWr;
  logic [BURST_BITS-1:0] memBurstLen;
  logic                  wValid;
  logic                  wReady;
  logic [8*BYTES-1:0]    memDataIn;
  logic [BYTES-1:0]      memStrb;
  logic                  rValid;
  logic                  rReady;
  logic                  rLast;
  logic [8*BYTES-1:0]    memDataOut;
  logic                  wrDone;
  logic                  memBusyOut;

  modport master (
    output cmdValid, memAddr, memWr, memBurstLen,
    output wValid, memDataIn, memStrb, rReady,
    input  cmdReady, wReady, rValid, rLast, memDataOut, wrDone, memBusyOut
  );

  modport slave (
    input  cmdValid, memAddr, memWr, memBurstLen,
    input  wValid, memDataIn, memStrb, rReady,
    output cmdReady, wReady, rValid, rLast, memDataOut, wrDone, memBusyOut
  );
endinterface

// File: rtl/banked_byte_mem.sv
// Byte-banked word memory with burst transfers and cycle-counted access latency.
// One bank per byte lane; a single FSM sequences command, write-beat and read-beat phases.
module banked_byte_mem #(
  parameter int BYTES      = 4,
  parameter int DEPTH      = 1024,
  parameter int ADDR_SIZE  = 32,
  parameter int BURST_BITS = 2,
  parameter int RD_LATENCY = 2,
  parameter int WR_LATENCY = 2
) (
  input logic               clk,
  input logic               reset,
  banked_byte_mem_if.slave  bus
);

  localparam int OFF_W   = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int LAT_W   = $clog2(MAX_LAT + 1);

  localparam logic [LAT_W-1:0] RD_LAT = LAT_W'(RD_LATENCY);
  localparam logic [LAT_W-1:0] WR_LAT = LAT_W'(WR_LATENCY);

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    WR_WAIT,
    RD_WAIT,
    RD_RESP
  } state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [IDX_W-1:0]      r_wordIdx;
  logic [BURST_BITS-1:0] r_beatCnt;
  logic [LAT_W-1:0]      r_latCnt;
  logic [8*BYTES-1:0]    r_dataOut;
  logic                  r_wrDone;
  logic [8*BYTES-1:0]    w_rdWord;
  logic                  w_latDone;
  logic                  w_lastBeat;
  logic                  w_wBeat;
  logic                  w_cmdReady;
  logic                  w_wReady;
  logic                  w_rValid;
  logic                  w_rLast;
  logic                  w_busy;

  assign w_latDone  = (r_latCnt == LAT_W'(1));
  assign w_lastBeat = (r_beatCnt == '0);
  // Writes are suppressed in a reset cycle so an abandoned burst leaves no trace
  assign w_wBeat    = (r_state == WR_DATA) && bus.wValid && reset;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_cmdReady  = 1'b0;
    w_wReady    = 1'b0;
    w_rValid    = 1'b0;
    w_rLast     = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      IDLE: begin
        w_cmdReady = 1'b1;
        w_busy     = 1'b0;
        if (bus.cmdValid) begin
          w_nextState = bus.memWr ? WR_DATA : RD_WAIT;
        end
      end
      WR_DATA: begin
        w_wReady = 1'b1;
        if (bus.wValid) begin
          w_nextState = WR_WAIT;
        end
      end
      WR_WAIT: begin
        if (w_latDone) begin
          w_nextState = w_lastBeat ? IDLE : WR_DATA;
        end
      end
      RD_WAIT: begin
        if (w_latDone) begin
          w_nextState = RD_RESP;
        end
      end
      RD_RESP: begin
        w_rValid = 1'b1;
        w_rLast  = w_lastBeat;
        if (bus.rReady) begin
          w_nextState = w_lastBeat ? IDLE : RD_WAIT;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Latency counter reaches 1 on the cycle whose closing edge completes the wait
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wordIdx <= '0;
      r_beatCnt <= '0;
      r_latCnt  <= '0;
      r_dataOut <= '0;
      r_wrDone  <= 1'b0;
    end else begin
      r_wrDone <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.cmdValid) begin
            r_wordIdx <= bus.memAddr[OFF_W +: IDX_W];
            r_beatCnt <= bus.memBurstLen;
            r_latCnt  <= bus.memWr ? WR_LAT : RD_LAT;
          end
        end
        WR_DATA: begin
          if (bus.wValid) begin
            r_latCnt <= WR_LAT;
          end
        end
        WR_WAIT: begin
          if (w_latDone) begin
            if (w_lastBeat) begin
              r_wrDone <= 1'b1;
            end else begin
              r_beatCnt <= r_beatCnt - 1'b1;
              r_wordIdx <= r_wordIdx + 1'b1;
            end
          end else begin
            r_latCnt <= r_latCnt - 1'b1;
          end
        end
        RD_WAIT: begin
          if (w_latDone) begin
            r_dataOut <= w_rdWord;
          end else begin
            r_latCnt <= r_latCnt - 1'b1;
          end
        end
        RD_RESP: begin
          if (bus.rReady && !w_lastBeat) begin
            r_beatCnt <= r_beatCnt - 1'b1;
            r_wordIdx <= r_wordIdx + 1'b1;
            r_latCnt  <= RD_LAT;
          end
        end
        default: begin
          r_latCnt <= '0;
        end
      endcase
    end
  end

  for (genvar b = 0; b < BYTES; b++) begin : g_bank
    logic [7:0] r_bank [DEPTH];

    always_ff @(posedge clk) begin
      if (w_wBeat && bus.memStrb[b]) begin
        r_bank[r_wordIdx] <= bus.memDataIn[8*b +: 8];
      end
    end

    assign w_rdWord[8*b +: 8] = r_bank[r_wordIdx];
  end

  assign bus.cmdReady   = w_cmdReady;
  assign bus.wReady     = w_wReady;
  assign bus.rValid     = w_rValid;
  assign bus.rLast      = w_rLast;
  assign bus.memDataOut = r_dataOut;
  assign bus.wrDone     = r_wrDone;
  assign bus.memBusyOut = w_busy;

endmodule

// File: tb/tb_banked_byte_mem.sv
// Directed bench for banked_byte_mem: write/read, strobes, burst backpressure,
// index wrap, busy rejection and reset in the middle of a write burst.
module tb_banked_byte_mem;

  localparam int BYTES      = 4;
  localparam int DEPTH      = 16;
  localparam int ADDR_SIZE  = 32;
  localparam int BURST_BITS = 2;
  localparam int RD_LAT     = 2;
  localparam int WR_LAT     = 2;
  localparam int TIMEOUT    = 50;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checkCount = 0;
  int   passCount = 0;

  banked_byte_mem_if #(.BYTES(BYTES), .ADDR_SIZE(ADDR_SIZE), .BURST_BITS(BURST_BITS)) bus ();

  banked_byte_mem #(
    .BYTES(BYTES), .DEPTH(DEPTH), .ADDR_SIZE(ADDR_SIZE), .BURST_BITS(BURST_BITS),
    .RD_LATENCY(RD_LAT), .WR_LATENCY(WR_LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
  endtask

  // Present a command at a falling edge and hold it until it is taken
  task automatic applyStimulus(input logic [31:0] addr, input logic wr, input logic [1:0] len);
    int waitCnt = 0;
    bus.cmdValid = 1'b1;
    bus.memAddr = addr;
    bus.memWr = wr;
    bus.memBurstLen = len;
    while (!bus.cmdReady && waitCnt < TIMEOUT) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("cmdReady", 32'(bus.cmdReady), 32'd1);
    @(negedge clk);
    bus.cmdValid = 1'b0;
  endtask

  task automatic writeBurst(input logic [31:0] addr, input logic [1:0] len,
                            input logic [127:0] dataVec, input logic [15:0] strbVec);
    int waitCnt;
    applyStimulus(addr, 1'b1, len);
    for (int b = 0; b <= int'(len); b++) begin
      waitCnt = 0;
      while (!bus.wReady && waitCnt < TIMEOUT) begin
        @(negedge clk);
        waitCnt++;
        checkOutput("wrDoneEarly", 32'(bus.wrDone), 32'd0);
      end
      checkOutput("wReady", 32'(bus.wReady), 32'd1);
      checkOutput("wReadyDelay", waitCnt, (b == 0) ? 32'd0 : 32'(WR_LAT));
      bus.wValid = 1'b1;
      bus.memDataIn = dataVec[32*b +: 32];
      bus.memStrb = strbVec[4*b +: 4];
      @(negedge clk);
      bus.wValid = 1'b0;
    end
    waitCnt = 0;
    while (!bus.wrDone && waitCnt < TIMEOUT) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("wrDoneDelay", waitCnt, 32'(WR_LAT));
    checkOutput("cmdReadyAtDone", 32'(bus.cmdReady), 32'd1);
    @(negedge clk);
    checkOutput("wrDoneOnePulse", 32'(bus.wrDone), 32'd0);
  endtask

  task automatic readBurst(input logic [31:0] addr, input logic [1:0] len,
                           input logic [127:0] expVec, input int stallBeat, input int stallCycles);
    int waitCnt;
    applyStimulus(addr, 1'b0, len);
    for (int b = 0; b <= int'(len); b++) begin
      waitCnt = 0;
      while (!bus.rValid && waitCnt < TIMEOUT) begin
        @(negedge clk);
        waitCnt++;
      end
      checkOutput("rValid", 32'(bus.rValid), 32'd1);
      checkOutput("rValidDelay", waitCnt, 32'(RD_LAT));
      checkOutput("rData", bus.memDataOut, expVec[32*b +: 32]);
      checkOutput("rLast", 32'(bus.rLast), 32'(b == int'(len)));
      if (b == stallBeat) begin
        repeat (stallCycles) begin
          @(negedge clk);
          checkOutput("rHoldValid", 32'(bus.rValid), 32'd1);
          checkOutput("rHoldData", bus.memDataOut, expVec[32*b +: 32]);
        end
      end
      bus.rReady = 1'b1;
      @(negedge clk);
      bus.rReady = 1'b0;
    end
    checkOutput("busyAfterRead", 32'(bus.memBusyOut), 32'd0);
  endtask

  task automatic checkResetOutputs();
    checkOutput("rstCmdReady", 32'(bus.cmdReady), 32'd1);
    checkOutput("rstWReady", 32'(bus.wReady), 32'd0);
    checkOutput("rstRValid", 32'(bus.rValid), 32'd0);
    checkOutput("rstRLast", 32'(bus.rLast), 32'd0);
    checkOutput("rstWrDone", 32'(bus.wrDone), 32'd0);
    checkOutput("rstBusy", 32'(bus.memBusyOut), 32'd0);
    checkOutput("rstDataOut", bus.memDataOut, 32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waitCnt;
    bus.cmdValid = 1'b0;
    bus.memAddr = '0;
    bus.memWr = 1'b0;
    bus.memBurstLen = '0;
    bus.wValid = 1'b0;
    bus.memDataIn = '0;
    bus.memStrb = '0;
    bus.rReady = 1'b0;
    repeat (2) @(negedge clk);
    checkResetOutputs();
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] single write then read");
    writeBurst(32'h10, 2'd0, {96'h0, 32'hDEADBEEF}, 16'h000F);
    readBurst(32'h10, 2'd0, {96'h0, 32'hDEADBEEF}, -1, 0);

    $display("[TB] partial strobe");
    writeBurst(32'h10, 2'd0, {96'h0, 32'h11223344}, 16'h0005);
    readBurst(32'h10, 2'd0, {96'h0, 32'hDE22BE44}, -1, 0);

    $display("[TB] burst read with backpressure");
    writeBurst(32'h10, 2'd3, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 16'hFFFF);
    readBurst(32'h10, 2'd3, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1, 3);

    $display("[TB] wrap-around");
    writeBurst(32'h3C, 2'd2, {32'h0, 32'd3, 32'd2, 32'd1}, 16'h0FFF);
    readBurst(32'h3C, 2'd2, {32'h0, 32'd3, 32'd2, 32'd1}, -1, 0);
    readBurst(32'h00, 2'd1, {64'h0, 32'd3, 32'd2}, -1, 0);
    readBurst(32'h3F, 2'd0, {96'h0, 32'd1}, -1, 0);

    $display("[TB] busy rejection");
    applyStimulus(32'h14, 1'b0, 2'd0);
    bus.cmdValid = 1'b1;
    bus.memWr = 1'b1;
    bus.memAddr = 32'h3C;
    checkOutput("busyCmdReady0", 32'(bus.cmdReady), 32'd0);
    checkOutput("busyFlag", 32'(bus.memBusyOut), 32'd1);
    @(negedge clk);
    checkOutput("busyCmdReady1", 32'(bus.cmdReady), 32'd0);
    checkOutput("busyNoWReady1", 32'(bus.wReady), 32'd0);
    @(negedge clk);
    checkOutput("busyRValid", 32'(bus.rValid), 32'd1);
    checkOutput("busyRData", bus.memDataOut, 32'hA1);
    checkOutput("busyCmdReady2", 32'(bus.cmdReady), 32'd0);
    bus.cmdValid = 1'b0;
    bus.rReady = 1'b1;
    @(negedge clk);
    bus.rReady = 1'b0;
    checkOutput("busyIdle", 32'(bus.memBusyOut), 32'd0);
    @(negedge clk);
    checkOutput("busyNoWrite", 32'(bus.wReady), 32'd0);

    $display("[TB] reset mid write burst");
    writeBurst(32'h24, 2'd0, {96'h0, 32'h12345678}, 16'h000F);
    applyStimulus(32'h20, 1'b1, 2'd3);
    bus.wValid = 1'b1;
    bus.memDataIn = 32'h55AA55AA;
    bus.memStrb = 4'hF;
    @(negedge clk);
    bus.wValid = 1'b0;
    waitCnt = 0;
    while (!bus.wReady && waitCnt < TIMEOUT) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("rstBeat1Ready", 32'(bus.wReady), 32'd1);
    bus.wValid = 1'b1;
    bus.memDataIn = 32'h66666666;
    reset = 1'b0;
    @(negedge clk);
    bus.wValid = 1'b0;
    checkResetOutputs();
    reset = 1'b1;
    @(negedge clk);
    readBurst(32'h20, 2'd0, {96'h0, 32'h55AA55AA}, -1, 0);
    readBurst(32'h24, 2'd0, {96'h0, 32'h12345678}, -1, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
